// File: rtl/lsu_dmem_port.sv
// MEM-stage load/store unit: aligns addresses, byte enables and store data for the data cache,
// stalls the pipeline until the cache responds, and returns sign/zero-extended load data.
module lsu_dmem_port #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic              flush,
    output logic [ADDR_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [3:0]        dmem_mbe,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misaligned
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MBE_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dmem_address_q, dmem_address_d;
    logic                dmem_read_q, dmem_read_d;
    logic                dmem_write_q, dmem_write_d;
    logic [MBE_W-1:0]    dmem_mbe_q, dmem_mbe_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                done_q, done_d;
    logic                misaligned_q, misaligned_d;
    logic                kill_q, kill_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;

    logic                access;
    logic [1:0]          off;
    logic                legal;
    logic [MBE_W-1:0]    mbe_calc;
    logic [DATA_W-1:0]   wdata_calc;
    logic [DATA_W-1:0]   rdata_sh;
    logic [DATA_W-1:0]   load_ext;

    assign access = req_valid & (mem_read | mem_write) & ~flush;
    assign off    = addr[1:0];

    // Size decode from funct3[1:0]; unused encodings fall through to word
    always_comb begin
        legal      = 1'b0;
        mbe_calc   = '0;
        wdata_calc = '0;
        case (funct3[1:0])
            2'b00: begin
                legal      = 1'b1;
                mbe_calc   = MBE_W'(4'b0001 << off);
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                legal      = ~off[0];
                mbe_calc   = MBE_W'(4'b0011 << off);
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                legal      = (off == 2'b00);
                mbe_calc   = 4'b1111;
                wdata_calc = store_data;
            end
        endcase
    end

    // Load extraction uses the funct3/offset captured at issue, since inputs are ignored in BUSY
    assign rdata_sh = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = dmem_rdata;
        case (funct3_q[1:0])
            2'b00: load_ext = funct3_q[2] ? {24'b0, rdata_sh[7:0]}
                                          : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01: load_ext = funct3_q[2] ? {16'b0, rdata_sh[15:0]}
                                          : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        dmem_address_d = dmem_address_q;
        dmem_read_d    = dmem_read_q;
        dmem_write_d   = dmem_write_q;
        dmem_mbe_d     = dmem_mbe_q;
        dmem_wdata_d   = dmem_wdata_q;
        load_data_d    = load_data_q;
        kill_d         = kill_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        done_d         = 1'b0;
        misaligned_d   = 1'b0;
        stall          = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        stall          = 1'b1;
                        dmem_address_d = {addr[ADDR_W-1:2], 2'b00};
                        dmem_read_d    = mem_read;
                        dmem_write_d   = ~mem_read & mem_write;
                        dmem_mbe_d     = mbe_calc;
                        dmem_wdata_d   = wdata_calc;
                        funct3_d       = funct3;
                        off_d          = off;
                        kill_d         = 1'b0;
                        state_d        = BUSY;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (dmem_resp) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    if (dmem_read_q) begin
                        load_data_d = load_ext;
                    end
                    // A flush arriving with the response still kills the access
                    if (kill_q | flush) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dmem_address_q <= '0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_mbe_q     <= '0;
            dmem_wdata_q   <= '0;
            load_data_q    <= '0;
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            kill_q         <= 1'b0;
            funct3_q       <= '0;
            off_q          <= '0;
        end else begin
            state_q        <= state_d;
            dmem_address_q <= dmem_address_d;
            dmem_read_q    <= dmem_read_d;
            dmem_write_q   <= dmem_write_d;
            dmem_mbe_q     <= dmem_mbe_d;
            dmem_wdata_q   <= dmem_wdata_d;
            load_data_q    <= load_data_d;
            done_q         <= done_d;
            misaligned_q   <= misaligned_d;
            kill_q         <= kill_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
        end
    end

    assign dmem_address = dmem_address_q;
    assign dmem_read    = dmem_read_q;
    assign dmem_write   = dmem_write_q;
    assign dmem_mbe     = dmem_mbe_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign load_data    = load_data_q;
    assign done         = done_q;
    assign misaligned   = misaligned_q;

endmodule
